// File: rtl/regfile_write_decoder_if.sv
// Write-side bus of the register file: write request, clear control, decode
// status and the flattened register image consumed by the read-mux trees.
interface regfile_write_decoder_if #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32
) ();
  localparam int ADDR_W = $clog2(NREGS);

  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   clr_start;
  logic                   busy;
  logic                   wr_accept;
  logic [NREGS-1:0]       wr_sel;
  logic [NREGS*WIDTH-1:0] regs;

  modport master (
    output wr_en, wr_addr, wr_data, clr_start,
    input  busy, wr_accept, wr_sel, regs
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr_start,
    output busy, wr_accept, wr_sel, regs
  );
endinterface

// File: rtl/regfile_write_decoder.sv
// Register-file write side: 5:32 write-address demux, per-row storage with a
// hardwired-zero row, and a one-register-per-cycle clear sweep.
module regfile_write_decoder #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input logic                   clk,
  input logic                   reset_n,
  regfile_write_decoder_if.slave bus
);
  localparam int ADDR_W = $clog2(NREGS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [ADDR_W-1:0]      ptr_r;
  logic [ADDR_W-1:0]      ptr_nxt_s;
  logic                   busy_r;
  logic                   busy_nxt_s;
  logic                   in_range_s;
  logic                   wr_accept_s;
  logic [NREGS-1:0]       wr_sel_s;
  logic [NREGS*WIDTH-1:0] regs_s;

  // Addresses beyond the populated rows only exist when NREGS is below 2**ADDR_W.
  assign in_range_s  = (32'(bus.wr_addr) < 32'(NREGS));
  assign wr_accept_s = bus.wr_en & ~busy_r & in_range_s
                     & (bus.wr_addr != ADDR_W'(ZERO_REG));

  // One-hot row select of the accepted write.
  always_comb begin
    wr_sel_s = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      wr_sel_s[i] = wr_accept_s & (bus.wr_addr == ADDR_W'(i));
    end
  end

  // Clear-sweep state, pointer and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Sweep sequencing; a clr_start seen during CLEAR is deliberately ignored.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    busy_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.clr_start) begin
          state_nxt_s = ST_CLEAR;
          ptr_nxt_s   = {ADDR_W{1'b0}};
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (ptr_r == ADDR_W'(NREGS - 1)) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = {ADDR_W{1'b0}};
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_CLEAR;
          ptr_nxt_s   = ptr_r + ADDR_W'(32'd1);
          busy_nxt_s  = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = {ADDR_W{1'b0}};
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_row
    if (g == ZERO_REG) begin : g_zero
      assign regs_s[g*WIDTH +: WIDTH] = {WIDTH{1'b0}};
    end else begin : g_live
      logic             row_r;
      logic [WIDTH-1:0] data_r;
      logic             clr_hit_s;

      assign clr_hit_s = (state_r == ST_CLEAR) && (ptr_r == ADDR_W'(g));
      assign row_r     = wr_sel_s[g];

      // Row storage; sweep and write never coincide because writes are blocked while busy.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_r <= {WIDTH{1'b0}};
        end else if (clr_hit_s) begin
          data_r <= {WIDTH{1'b0}};
        end else if (row_r) begin
          data_r <= bus.wr_data;
        end else begin
          data_r <= data_r;
        end
      end

      assign regs_s[g*WIDTH +: WIDTH] = data_r;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.wr_accept = wr_accept_s;
  assign bus.wr_sel    = wr_sel_s;
  assign bus.regs      = regs_s;
endmodule
